dummy_accelerator_arbiter: RTL and testbench
============================================

# dummy_accelerator_arbiter

Shares one `dummy_accelerator_iterative` instance between `N_REQ` requesters. Requests are granted round-robin and issued one at a time, since the accelerator is iterative and holds a single outstanding operation. Each result is routed back to the requester that issued it. The block sits between the requester-side valid/ready ports and the accelerator's upstream and downstream handshakes.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 32: data width of rs1 and result.
- `IMM_WIDTH`, 11: immediate width.
- `conf_type_t`, `logic [IMM_WIDTH-1:0]`: immediate/config type.
- `tag_type_t`, `logic`: opaque tag, passed through unchanged.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `flush_i`, in, 1: synchronous abort of the current operation.
- `req_valid_i`, in, N_REQ: per-requester request valid.
- `req_ready_o`, out, N_REQ: per-requester accept; at most one bit high.
- `req_rs1_i`, in, N_REQ×WIDTH: rs1 operand per requester.
- `req_imm_i`, in, N_REQ×conf_type_t: immediate per requester.
- `req_tag_i`, in, N_REQ×tag_type_t: tag per requester.
- `rsp_valid_o`, out, N_REQ: response valid, one-hot or zero.
- `rsp_ready_i`, in, N_REQ: per-requester response ready.
- `rsp_result_o`, out, WIDTH: shared response data bus.
- `rsp_tag_o`, out, tag_type_t: shared response tag bus.
- `acc_valid_o`, out, 1: request valid to the accelerator.
- `acc_ready_i`, in, 1: accelerator accepts the request.
- `acc_rs1_o`, out, WIDTH: operand to the accelerator.
- `acc_imm_o`, out, conf_type_t: immediate to the accelerator.
- `acc_tag_o`, out, tag_type_t: tag to the accelerator.
- `acc_valid_i`, in, 1: accelerator result valid.
- `acc_ready_o`, out, 1: arbiter ready to take the result.
- `acc_result_i`, in, WIDTH: accelerator result.
- `acc_tag_i`, in, tag_type_t: accelerator result tag.
- `acc_flush_o`, out, 1: flush to the accelerator; equals `flush_i` combinationally.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.

- **IDLE**
  - If any `req_valid_i` bit is set, the round-robin arbiter picks the first set bit at or above `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready_o[w]`=1 combinationally for the winner `w`.
  - The winner's rs1/imm/tag are latched into the request buffer and `w` into `owner_q`.
  - Next state: ISSUE.
- **ISSUE**
  - `acc_valid_o`=1, driving the buffered payload.
  - On `acc_ready_i`: go to WAIT.
  - The payload stays stable while stalled.
- **WAIT**
  - `acc_ready_o`=1.
  - On `acc_valid_i`: latch `acc_result_i`/`acc_tag_i` into the response buffer and go to RESP.
- **RESP**
  - `rsp_valid_o[owner_q]`=1, driving the buffered result/tag.
  - On `rsp_ready_i[owner_q]`: set `rr_ptr` ← (owner_q+1) mod N_REQ and go to IDLE.
  - `rsp_ready_i` of non-owner requesters is ignored.
- **Fairness:** a requester that keeps valid asserted is served within N_REQ grants.
- **Flush:** `flush_i`=1 in any state forces IDLE next cycle.
  - Request and response buffers, `owner_q` and `rr_ptr` are cleared to 0.
  - No `req_ready_o` is asserted in the flush cycle.
  - The dropped operation produces no response.
- **`rr_ptr` width:** $clog2(N_REQ); wrap from N_REQ-1 to 0.
- **Arbitration scope:** `req_valid_i` is sampled only in IDLE; requests arriving in other states wait.

## Timing
- **Reset values:**
  - `req_ready_o`, `rsp_valid_o`, `acc_valid_o`, `acc_ready_o`, `busy_o` = 0.
  - All data outputs = 0.
  - `rr_ptr` = 0.
- **Minimum latency** for an accelerator that is always ready and responds in 1 cycle:
  - request accepted at cycle 0;
  - `acc_valid_o` at cycle 1;
  - result captured at cycle 2;
  - `rsp_valid_o` at cycle 3;
  - next grant no earlier than cycle 4.
- All outputs are registered-state-driven except `req_ready_o` (the IDLE arbitration result) and `acc_flush_o`.
- Reset mid-operation aborts immediately and asynchronously; no response is emitted.
- Flush in the same cycle as a handshake takes priority; the handshake is void.

## Structure
- Package `dummy_acc_arb_pkg`: FSM state enum `arb_state_e`; request struct (rs1, imm, tag) parameterized via the module.
- Sub-module `rr_arbiter`:
  - inputs: `req[N_REQ]`, `ptr`;
  - outputs: one-hot `gnt`, index `gnt_idx`, `gnt_valid`;
  - purely combinational, with a double-width masked priority encode.
- The top module holds the FSM, payload/response buffers, `owner_q` and `rr_ptr`.

## Test plan
- **Single request:** requester 2 sends rs1=0x0000_00FF, imm=0x00F with a 1-cycle accelerator → `acc_rs1_o`=0xFF at cycle 1; `rsp_valid_o`=4'b0100 with the returned result at cycle 3.
- **Round-robin:** all 4 valid continuously, `rsp_ready_i` all 1 → grant order 0,1,2,3,0; no requester is granted twice before the others.
- **Backpressure:** hold `acc_ready_i`=0 for 5 cycles in ISSUE → `acc_*` payload stable; `req_ready_o`=0 throughout. Hold `rsp_ready_i[owner]`=0 for 3 cycles → stays in RESP with data stable.
- **Wrong-owner ready:** requester 1 owns the response, `rsp_ready_i`=4'b1101 → no exit from RESP until bit 1 is raised.
- **Flush in WAIT:**
  - `flush_i` pulsed → `acc_flush_o`=1 that cycle; IDLE next cycle; no `rsp_valid_o`; `rr_ptr`=0.
  - The next request from requester 3 completes normally.
- **Async reset during RESP:** `rst_ni` low → all valids drop immediately; `busy_o`=0.

Source files
------------

// File: rtl/dummy_acc_arb_pkg.sv
// dummy_acc_arb_pkg: FSM encoding and index arithmetic shared by the accelerator arbiter
package dummy_acc_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b, input int unsigned n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr_i
module rr_arbiter
  import dummy_acc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             gnt_valid_o
);
  logic [2*N_REQ-1:0] dbl;
  int unsigned off;
  // Rotating a doubled copy puts ptr_i at bit 0, so the lowest set bit is the winner's offset.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    off = 0;
    for (int i = N_REQ - 1; i >= 0; i--) off = dbl[i] ? 32'(i) : off;
    gnt_valid_o = |req_i;
    gnt_idx_o = IW'(wrap_add(32'(ptr_i), off, N_REQ));
    gnt_o = gnt_valid_o ? N_REQ'(1) << gnt_idx_o : '0;
  end
endmodule

// File: rtl/dummy_accelerator_arbiter.sv
// dummy_accelerator_arbiter: round-robin sharing of one iterative accelerator between N_REQ requesters
module dummy_accelerator_arbiter
  import dummy_acc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IMM_WIDTH = 11,
  parameter type conf_type_t = logic [IMM_WIDTH-1:0],
  parameter type tag_type_t = logic,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic [N_REQ-1:0][WIDTH-1:0]   req_rs1_i,
  input  conf_type_t [N_REQ-1:0]        req_imm_i,
  input  tag_type_t [N_REQ-1:0]         req_tag_i,
  output logic [N_REQ-1:0]              rsp_valid_o,
  input  logic [N_REQ-1:0]              rsp_ready_i,
  output logic [WIDTH-1:0]              rsp_result_o,
  output tag_type_t                     rsp_tag_o,
  output logic                          acc_valid_o,
  input  logic                          acc_ready_i,
  output logic [WIDTH-1:0]              acc_rs1_o,
  output conf_type_t                    acc_imm_o,
  output tag_type_t                     acc_tag_o,
  input  logic                          acc_valid_i,
  output logic                          acc_ready_o,
  input  logic [WIDTH-1:0]              acc_result_i,
  input  tag_type_t                     acc_tag_i,
  output logic                          acc_flush_o,
  output logic                          busy_o
);
  typedef struct packed {
    logic [WIDTH-1:0] rs1;
    conf_type_t       imm;
    tag_type_t        tag;
  } req_t;
  arb_state_e       state_q;
  req_t             req_q;
  logic [IW-1:0]    owner_q, rr_ptr_q;
  logic [WIDTH-1:0] res_q;
  tag_type_t        res_tag_q;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );
  assign req_ready_o  = (state_q == IDLE && !flush_i) ? gnt : '0;
  assign acc_valid_o  = state_q == ISSUE;
  assign acc_rs1_o    = req_q.rs1;
  assign acc_imm_o    = req_q.imm;
  assign acc_tag_o    = req_q.tag;
  assign acc_ready_o  = state_q == WAIT;
  assign rsp_valid_o  = (state_q == RESP) ? N_REQ'(1) << owner_q : '0;
  assign rsp_result_o = res_q;
  assign rsp_tag_o    = res_tag_q;
  assign acc_flush_o  = flush_i;
  assign busy_o       = state_q != IDLE;
  // Flush outranks every handshake, so it is tested before the state dispatch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      res_q     <= '0;
      res_tag_q <= '0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      res_q     <= '0;
      res_tag_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_valid) begin
          req_q.rs1 <= req_rs1_i[gnt_idx];
          req_q.imm <= req_imm_i[gnt_idx];
          req_q.tag <= req_tag_i[gnt_idx];
          owner_q   <= gnt_idx;
          state_q   <= ISSUE;
        end
        ISSUE: if (acc_ready_i) state_q <= WAIT;
        WAIT: if (acc_valid_i) begin
          res_q     <= acc_result_i;
          res_tag_q <= acc_tag_i;
          state_q   <= RESP;
        end
        RESP: if (rsp_ready_i[owner_q]) begin
          rr_ptr_q <= IW'(wrap_add(32'(owner_q), 1, N_REQ));
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dummy_accelerator_arbiter.sv
// tb_dummy_accelerator_arbiter: scoreboard bench with a 1-cycle accelerator model
module tb_dummy_accelerator_arbiter;
  logic clk = 0, rst_ni = 0, flush_i = 0;
  logic [3:0] req_valid_i = 0, req_ready_o, rsp_valid_o, rsp_ready_i = 0;
  logic [3:0][31:0] req_rs1_i = '0;
  logic [3:0][10:0] req_imm_i = '0;
  logic [3:0] req_tag_i = '0;
  logic [31:0] rsp_result_o, acc_rs1_o, acc_result_i;
  logic rsp_tag_o, acc_valid_o, acc_ready_i = 1, acc_tag_o, acc_valid_i, acc_ready_o, acc_tag_i, acc_flush_o, busy_o;
  logic [10:0] acc_imm_o;
  int pass_cnt = 0, total = 0;
  typedef struct {int idx; logic [31:0] res; logic tag;} exp_t;
  exp_t sb[$];

  dummy_accelerator_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rs1_i(req_rs1_i),
    .req_imm_i(req_imm_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_rs1_o(acc_rs1_o), .acc_imm_o(acc_imm_o),
    .acc_tag_o(acc_tag_o), .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .acc_result_i(acc_result_i), .acc_tag_i(acc_tag_i), .acc_flush_o(acc_flush_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a, input logic [10:0] b);
    return a + 32'(b) + 32'h1000;
  endfunction

  // Accelerator: answers one cycle after accepting, drops its result on flush or reset.
  initial begin
    logic hs_req, hs_rsp, fl, t;
    logic [31:0] r;
    acc_valid_i = 0; acc_result_i = 0; acc_tag_i = 0;
    forever begin
      @(negedge clk); #4;
      hs_req = acc_valid_o && acc_ready_i && !flush_i && rst_ni;
      hs_rsp = acc_valid_i && acc_ready_o && !flush_i && rst_ni;
      fl = flush_i || !rst_ni;
      r = f(acc_rs1_o, acc_imm_o);
      t = acc_tag_o;
      @(posedge clk); #1;
      if (fl || !rst_ni) acc_valid_i = 0;
      else begin
        if (hs_rsp) acc_valid_i = 0;
        if (hs_req) begin acc_valid_i = 1; acc_result_i = r; acc_tag_i = t; end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if ({req_ready_o, rsp_valid_o} !== 8'h0) $display("FAIL reset_valids got=%h exp=00", {req_ready_o, rsp_valid_o}); else pass_cnt++;
    total++; if ({acc_valid_o, acc_ready_o, busy_o} !== 3'b000) $display("FAIL reset_ctrl got=%b exp=000", {acc_valid_o, acc_ready_o, busy_o}); else pass_cnt++;
    total++; if ({acc_rs1_o, acc_imm_o, acc_tag_o, rsp_result_o, rsp_tag_o} !== 77'h0) $display("FAIL reset_data got=%h exp=0", {acc_rs1_o, acc_imm_o, acc_tag_o, rsp_result_o, rsp_tag_o}); else pass_cnt++;
    @(negedge clk); rst_ni = 1;
  endtask

  task automatic test_single();
    logic [31:0] e;
    e = f(32'hFF, 11'h00F);
    @(negedge clk);
    req_valid_i = 4'b0100; req_rs1_i[2] = 32'hFF; req_imm_i[2] = 11'h00F; req_tag_i[2] = 1'b1; rsp_ready_i = 4'b0100;
    #1;
    total++; if (req_ready_o !== 4'b0100) $display("FAIL single_grant got=%b exp=0100", req_ready_o); else pass_cnt++;
    @(negedge clk); req_valid_i = 0; #1;
    total++; if ({acc_valid_o, acc_rs1_o, acc_imm_o, acc_tag_o} !== {1'b1, 32'hFF, 11'h00F, 1'b1}) $display("FAIL single_issue got=%h exp=%h", {acc_valid_o, acc_rs1_o, acc_imm_o, acc_tag_o}, {1'b1, 32'hFF, 11'h00F, 1'b1}); else pass_cnt++;
    @(negedge clk); #1;
    total++; if ({acc_ready_o, rsp_valid_o} !== 5'b10000) $display("FAIL single_wait got=%b exp=10000", {acc_ready_o, rsp_valid_o}); else pass_cnt++;
    @(negedge clk); #1;
    total++; if ({rsp_valid_o, rsp_result_o, rsp_tag_o} !== {4'b0100, e, 1'b1}) $display("FAIL single_resp got=%h exp=%h", {rsp_valid_o, rsp_result_o, rsp_tag_o}, {4'b0100, e, 1'b1}); else pass_cnt++;
    @(negedge clk); rsp_ready_i = 0; #1;
    total++; if (busy_o !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] e;
    @(negedge clk);
    req_valid_i = 4'b0010; req_rs1_i[1] = 32'h1234_5678; req_imm_i[1] = 11'h7FF; rsp_ready_i = 4'b1111;
    #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL flush_pre_grant got=%b exp=0010", req_ready_o); else pass_cnt++;
    @(negedge clk); req_valid_i = 0;
    @(negedge clk); flush_i = 1; #1;
    total++; if ({acc_flush_o, acc_ready_o, acc_valid_i} !== 3'b111) $display("FAIL flush_wait got=%b exp=111", {acc_flush_o, acc_ready_o, acc_valid_i}); else pass_cnt++;
    @(negedge clk); flush_i = 0; #1;
    total++; if ({busy_o, rsp_valid_o, acc_flush_o} !== 6'b0) $display("FAIL flush_idle got=%b exp=000000", {busy_o, rsp_valid_o, acc_flush_o}); else pass_cnt++;
    total++; if (dut.rr_ptr_q !== 2'd0) $display("FAIL flush_rr_ptr got=%0d exp=0", dut.rr_ptr_q); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++; if ({busy_o, rsp_valid_o} !== 5'b0) $display("FAIL flush_no_rsp got=%b exp=00000", {busy_o, rsp_valid_o}); else pass_cnt++;
    end
    @(negedge clk); flush_i = 1; req_valid_i = 4'b0001; #1;
    total++; if (req_ready_o !== 4'b0000) $display("FAIL flush_no_ready got=%b exp=0000", req_ready_o); else pass_cnt++;
    @(negedge clk); flush_i = 0;
    req_valid_i = 4'b1000; req_rs1_i[3] = 32'hCAFE_0003; req_imm_i[3] = 11'h123; req_tag_i[3] = 1'b0;
    e = f(32'hCAFE_0003, 11'h123);
    #1;
    total++; if ({busy_o, req_ready_o} !== 5'b01000) $display("FAIL flush_next_grant got=%b exp=01000", {busy_o, req_ready_o}); else pass_cnt++;
    @(negedge clk); req_valid_i = 0;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if ({rsp_valid_o, rsp_result_o, rsp_tag_o} !== {4'b1000, e, 1'b0}) $display("FAIL flush_next_resp got=%h exp=%h", {rsp_valid_o, rsp_result_o, rsp_tag_o}, {4'b1000, e, 1'b0}); else pass_cnt++;
    @(negedge clk); rsp_ready_i = 0; #1;
    total++; if (busy_o !== 1'b0) $display("FAIL flush_next_done got=%b exp=0", busy_o); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int ptr_m = 0, grants = 0, rsps = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      req_rs1_i[i] = $urandom; req_imm_i[i] = 11'($urandom); req_tag_i[i] = 1'($urandom);
    end
    rsp_ready_i = 4'b1111;
    for (int c = 0; c < 60 && rsps < 5; c++) begin
      @(negedge clk);
      req_valid_i = (grants < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (req_ready_o !== 4'b0000) begin
        total++; if (req_ready_o !== 4'(1 << ptr_m)) $display("FAIL rr_grant got=%b exp=%b", req_ready_o, 4'(1 << ptr_m)); else pass_cnt++;
        sb.push_back('{ptr_m, f(req_rs1_i[ptr_m], req_imm_i[ptr_m]), req_tag_i[ptr_m]});
        grants++;
      end
      if (rsp_valid_o !== 4'b0000) begin
        if (sb.size() == 0) begin
          total++; $display("FAIL rr_unexpected_rsp got=%b exp=none", rsp_valid_o);
        end else begin
          e = sb.pop_front();
          total++; if ({rsp_valid_o, rsp_result_o, rsp_tag_o} !== {4'(1 << e.idx), e.res, e.tag}) $display("FAIL rr_rsp got=%h exp=%h", {rsp_valid_o, rsp_result_o, rsp_tag_o}, {4'(1 << e.idx), e.res, e.tag}); else pass_cnt++;
          ptr_m = (e.idx + 1) % 4;
          rsps++;
        end
      end
    end
    total++; if (rsps != 5 || sb.size() != 0) $display("FAIL rr_complete got=%0d exp=5", rsps); else pass_cnt++;
    @(negedge clk); rsp_ready_i = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    e = f(32'hDEAD_BEEF, 11'h155);
    acc_ready_i = 0; req_valid_i = 4'b0001; req_rs1_i[0] = 32'hDEAD_BEEF; req_imm_i[0] = 11'h155; req_tag_i[0] = 1'b0;
    #1;
    total++; if (req_ready_o !== 4'b0001) $display("FAIL bp_grant got=%b exp=0001", req_ready_o); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      total++; if ({acc_valid_o, acc_rs1_o, acc_imm_o, acc_tag_o, req_ready_o} !== {1'b1, 32'hDEAD_BEEF, 11'h155, 1'b0, 4'b0}) $display("FAIL bp_issue_stall got=%h exp=%h", {acc_valid_o, acc_rs1_o, acc_imm_o, acc_tag_o, req_ready_o}, {1'b1, 32'hDEAD_BEEF, 11'h155, 1'b0, 4'b0}); else pass_cnt++;
    end
    @(negedge clk); acc_ready_i = 1; req_valid_i = 0;
    @(negedge clk); #1;
    total++; if (acc_ready_o !== 1'b1) $display("FAIL bp_wait got=%b exp=1", acc_ready_o); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++; if ({rsp_valid_o, rsp_result_o} !== {4'b0001, e}) $display("FAIL bp_resp_stall got=%h exp=%h", {rsp_valid_o, rsp_result_o}, {4'b0001, e}); else pass_cnt++;
    end
    @(negedge clk); rsp_ready_i = 4'b0001; #1;
    total++; if (rsp_valid_o !== 4'b0001) $display("FAIL bp_resp_release got=%b exp=0001", rsp_valid_o); else pass_cnt++;
    @(negedge clk); rsp_ready_i = 0; #1;
    total++; if (busy_o !== 1'b0) $display("FAIL bp_done got=%b exp=0", busy_o); else pass_cnt++;
  endtask

  task automatic test_wrong_owner();
    logic [31:0] e;
    e = f(32'h0BAD_F00D, 11'h042);
    @(negedge clk);
    req_valid_i = 4'b0010; req_rs1_i[1] = 32'h0BAD_F00D; req_imm_i[1] = 11'h042; req_tag_i[1] = 1'b1; rsp_ready_i = 4'b1101;
    #1;
    total++; if (req_ready_o !== 4'b0010) $display("FAIL wo_grant got=%b exp=0010", req_ready_o); else pass_cnt++;
    @(negedge clk); req_valid_i = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++; if ({rsp_valid_o, busy_o} !== 5'b00101) $display("FAIL wo_hold got=%b exp=00101", {rsp_valid_o, busy_o}); else pass_cnt++;
    end
    @(negedge clk); rsp_ready_i = 4'b0010; #1;
    total++; if ({rsp_valid_o, rsp_result_o, rsp_tag_o} !== {4'b0010, e, 1'b1}) $display("FAIL wo_resp got=%h exp=%h", {rsp_valid_o, rsp_result_o, rsp_tag_o}, {4'b0010, e, 1'b1}); else pass_cnt++;
    @(negedge clk); rsp_ready_i = 0; #1;
    total++; if (busy_o !== 1'b0) $display("FAIL wo_done got=%b exp=0", busy_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid_i = 4'b0100; req_rs1_i[2] = 32'h5555_AAAA; rsp_ready_i = 0;
    #1;
    total++; if (req_ready_o !== 4'b0100) $display("FAIL ar_grant got=%b exp=0100", req_ready_o); else pass_cnt++;
    @(negedge clk); req_valid_i = 0;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (rsp_valid_o !== 4'b0100) $display("FAIL ar_resp got=%b exp=0100", rsp_valid_o); else pass_cnt++;
    #1 rst_ni = 0;
    #1;
    total++; if ({rsp_valid_o, req_ready_o, acc_valid_o, acc_ready_o, busy_o} !== 11'b0) $display("FAIL ar_immediate got=%b exp=0", {rsp_valid_o, req_ready_o, acc_valid_o, acc_ready_o, busy_o}); else pass_cnt++;
    @(negedge clk); rst_ni = 1;
    repeat (2) begin
      @(negedge clk); #1;
      total++; if ({rsp_valid_o, busy_o} !== 5'b0) $display("FAIL ar_after got=%b exp=00000", {rsp_valid_o, busy_o}); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flush();
    test_round_robin();
    test_backpressure();
    test_wrong_owner();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
